// File: rtl/wb_sequencer.sv
// Writeback sequencer: turns decode writeback requests into mux select and RegFile
// write controls, sequencing data-memory loads over a fixed read latency.
module wb_sequencer #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned REG_AW  = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic [1:0]        ReqSrc,
  input  logic [REG_AW-1:0] ReqDst,
  output logic              ReqReady,
  output logic              Stall,
  output logic              MemRdEn,
  output logic [1:0]        Sel,
  output logic              RegWrEn,
  output logic [REG_AW-1:0] RegWrAddr,
  output logic              ErrIllegal
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              err_q, err_d;

  // State register; reset discards any pending load.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  // Next-state and combinational outputs; everything forced low while Reset is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dst_d     = dst_q;
    err_d     = err_q;
    ReqReady  = 1'b0;
    MemRdEn   = 1'b0;
    Sel       = SRC_MEM;
    RegWrEn   = 1'b0;
    RegWrAddr = '0;
    if (!Reset) begin
      unique case (state_q)
        ST_IDLE: begin
          ReqReady = 1'b1;
          if (ReqValid) begin
            unique case (ReqSrc)
              SRC_ALU, SRC_IMM: begin
                Sel       = ReqSrc;
                RegWrEn   = 1'b1;
                RegWrAddr = ReqDst;
              end
              SRC_MEM: begin
                MemRdEn = 1'b1;
                dst_d   = ReqDst;
                if (MEM_LAT == 1) begin
                  state_d = ST_WRITE;
                end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_WAIT: begin
          RegWrAddr = dst_q;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          RegWrEn   = 1'b1;
          RegWrAddr = dst_q;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign Stall      = ReqValid & ~ReqReady & ~Reset;
  assign ErrIllegal = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: a MEM_LAT=2 and a MEM_LAT=1 instance share stimulus and are
// checked every cycle against a load-countdown reference model.
module tb_wb_sequencer;

  localparam int unsigned AW = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          ReqValid;
  logic [1:0]    ReqSrc;
  logic [AW-1:0] ReqDst;

  logic          rdy_a, stl_a, rd_a, wr_a, err_a;
  logic [1:0]    sel_a;
  logic [AW-1:0] addr_a;
  logic          rdy_b, stl_b, rd_b, wr_b, err_b;
  logic [1:0]    sel_b;
  logic [AW-1:0] addr_b;

  wb_sequencer #(.MEM_LAT(2), .REG_AW(AW)) dut_a (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqSrc(ReqSrc), .ReqDst(ReqDst),
    .ReqReady(rdy_a), .Stall(stl_a), .MemRdEn(rd_a), .Sel(sel_a), .RegWrEn(wr_a),
    .RegWrAddr(addr_a), .ErrIllegal(err_a)
  );

  wb_sequencer #(.MEM_LAT(1), .REG_AW(AW)) dut_b (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqSrc(ReqSrc), .ReqDst(ReqDst),
    .ReqReady(rdy_b), .Stall(stl_b), .MemRdEn(rd_b), .Sel(sel_b), .RegWrEn(wr_b),
    .RegWrAddr(addr_b), .ErrIllegal(err_b)
  );

  always #5 Clk = ~Clk;

  // Reference model: cycles left until a pending load has written back, its dst, sticky error.
  int            busy [2];
  logic [AW-1:0] pdst [2];
  logic          merr [2];
  int            n_cmp;
  int            n_err;

  function automatic int lat(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Observed outputs packed as {ready, stall, rd, sel, wr, addr, err}.
  function automatic logic [9:0] obs(int i);
    if (i == 0) return {rdy_a, stl_a, rd_a, sel_a, wr_a, addr_a, err_a};
    return {rdy_b, stl_b, rd_b, sel_b, wr_b, addr_b, err_b};
  endfunction

  function automatic logic [9:0] predict(int i);
    logic rdy = 1'b0, stl = 1'b0, rd = 1'b0, wr = 1'b0, er = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [AW-1:0] ad = '0;
    if (!Reset) begin
      er = merr[i];
      if (busy[i] == 0) begin
        rdy = 1'b1;
        if (ReqValid) begin
          if (ReqSrc == 2'd1 || ReqSrc == 2'd2) begin
            sel = ReqSrc;
            wr  = 1'b1;
            ad  = ReqDst;
          end else if (ReqSrc == 2'd0) begin
            rd = 1'b1;
          end
        end
      end else begin
        stl = ReqValid;
        ad  = pdst[i];
        wr  = (busy[i] == 1);
      end
    end
    return {rdy, stl, rd, sel, wr, ad, er};
  endfunction

  task automatic tick();
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        busy[i] = 0;
        pdst[i] = '0;
        merr[i] = 1'b0;
      end else if (busy[i] > 0) begin
        busy[i] = busy[i] - 1;
      end else if (ReqValid) begin
        if (ReqSrc == 2'd0) begin
          busy[i] = lat(i);
          pdst[i] = ReqDst;
        end else if (ReqSrc == 2'd3) begin
          merr[i] = 1'b1;
        end
      end
    end
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [AW-1:0] d);
    ReqValid = v;
    ReqSrc   = s;
    ReqDst   = d;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd1, 3'd5);
    n_cmp++;
    if ({rdy_a, stl_a, rd_a, wr_a, sel_a, addr_a, err_a, rdy_b, wr_b, rd_b} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got a=%b b=%b want all zero", obs(0), obs(1));
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== predict(i)) begin
        n_err++;
        $display("FAIL reset_model lat=%0d got=%b want=%b", lat(i), obs(i), predict(i));
      end
    end
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 2'd1, 3'd5);
    n_cmp++;
    if ({sel_a, wr_a, addr_a, rdy_a, stl_a} !== {2'd1, 1'b1, 3'd5, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL alu_same_cycle got sel=%0d wr=%b addr=%0d rdy=%b stall=%b want 1 1 5 1 0",
               sel_a, wr_a, addr_a, rdy_a, stl_a);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== predict(i)) begin
        n_err++;
        $display("FAIL alu_model lat=%0d got=%b want=%b", lat(i), obs(i), predict(i));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]    src [2] = '{2'd2, 2'd1};
    logic [AW-1:0] dst [2] = '{3'd2, 3'd3};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, src[k], dst[k]);
      n_cmp++;
      if ({wr_a, sel_a, addr_a} !== {1'b1, src[k], dst[k]}) begin
        n_err++;
        $display("FAIL b2b_%0d got wr=%b sel=%0d addr=%0d want 1 %0d %0d",
                 k, wr_a, sel_a, addr_a, src[k], dst[k]);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== predict(i)) begin
          n_err++;
          $display("FAIL b2b_model lat=%0d got=%b want=%b", lat(i), obs(i), predict(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_load();
    int wr_at [2] = '{-1, -1};
    int rdy_at [2] = '{-1, -1};
    drive(1'b1, 2'd0, 3'd6);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== predict(i)) begin
        n_err++;
        $display("FAIL load_issue lat=%0d got=%b want=%b", lat(i), obs(i), predict(i));
      end
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 2'd1, 3'd1);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== predict(i)) begin
          n_err++;
          $display("FAIL load_cycle%0d lat=%0d got=%b want=%b", c, lat(i), obs(i), predict(i));
        end
      end
      if (wr_a && wr_at[0] < 0) wr_at[0] = c;
      if (wr_b && wr_at[1] < 0) wr_at[1] = c;
      if (rdy_a && rdy_at[0] < 0) rdy_at[0] = c;
      if (rdy_b && rdy_at[1] < 0) rdy_at[1] = c;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (wr_at[i] != lat(i) || rdy_at[i] != lat(i) + 1) begin
        n_err++;
        $display("FAIL load_timing lat=%0d got wr@%0d rdy@%0d want wr@%0d rdy@%0d",
                 lat(i), wr_at[i], rdy_at[i], lat(i), lat(i) + 1);
      end
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'd3, 3'd7);
    n_cmp++;
    if ({wr_a, rd_a, err_a} !== 3'b000) begin
      n_err++;
      $display("FAIL illegal_issue got wr=%b rd=%b err=%b want 0 0 0", wr_a, rd_a, err_a);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, (c == 1) ? 2'd0 : 2'd2, 3'(c));
      n_cmp++;
      if ({err_a, err_b} !== 2'b11) begin
        n_err++;
        $display("FAIL illegal_sticky cycle%0d got a=%b b=%b want 1 1", c, err_a, err_b);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== predict(i)) begin
          n_err++;
          $display("FAIL illegal_model lat=%0d got=%b want=%b", lat(i), obs(i), predict(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'd0, 3'd0);
      tick();
    end
    drive(1'b1, 2'd0, 3'd5);
    tick();
    drive(1'b0, 2'd0, 3'd0);
    n_cmp++;
    if ({wr_b, addr_b, addr_a, rdy_a} !== {1'b1, 3'd5, 3'd5, 1'b0}) begin
      n_err++;
      $display("FAIL pre_reset got wr_b=%b addr_b=%0d addr_a=%0d rdy_a=%b want 1 5 5 0",
               wr_b, addr_b, addr_a, rdy_a);
    end
    #2;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({wr_a, rd_a, rdy_a, wr_b, rd_b, rdy_b, err_a} !== 7'b0) begin
      n_err++;
      $display("FAIL async_reset got a wr=%b rd=%b rdy=%b b wr=%b rd=%b rdy=%b want all 0",
               wr_a, rd_a, rdy_a, wr_b, rd_b, rdy_b);
    end
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 2'd0, 3'd0);
      n_cmp++;
      if ({wr_a, wr_b} !== 2'b00) begin
        n_err++;
        $display("FAIL late_write cycle%0d got wr_a=%b wr_b=%b want 0 0", c, wr_a, wr_b);
      end
      tick();
    end
    drive(1'b1, 2'd2, 3'd1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== predict(i) || obs(i) !== {1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'd1, 1'b0}) begin
        n_err++;
        $display("FAIL post_reset_req lat=%0d got=%b want=%b", lat(i), obs(i), predict(i));
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Reset = ($urandom_range(0, 99) < 2);
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            AW'($urandom));
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs(i) !== predict(i)) begin
          n_err++;
          $display("FAIL random_c%0d lat=%0d got=%b want=%b", c, lat(i), obs(i), predict(i));
        end
      end
      tick();
    end
    Reset = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqSrc   = 2'd0;
    ReqDst   = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0;
      pdst[i] = '0;
      merr[i] = 1'b0;
    end
    #3;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_illegal();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Control-side counterpart of the 8-bit writeback source mux. Accepts per-instruction writeback requests from decode and produces the mux select, RegFile write enable and write address.
- ALU and immediate writebacks complete in the request cycle.
- Data-memory loads issue a read strobe, wait the fixed memory read latency, then perform the RegFile write with the mux steered to memory data.
- Sits between decode/control and the writeback mux/RegFile; stalls the front end while a load is outstanding.

Parameters:
MEM_LAT, 2, data memory read latency in cycles from MemRdEn to valid data (legal 1..15)
REG_AW, 3, RegFile address width

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
ReqValid  input  1  decode presents a writeback request this cycle
ReqSrc  input  2  source: 0=MEM, 1=ALU, 2=IMM, 3=reserved/illegal
ReqDst  input  REG_AW  destination register
ReqReady  output  1  sequencer can accept a request this cycle
Stall  output  1  ReqValid & ~ReqReady; freezes PC/decode
MemRdEn  output  1  one-cycle data memory read strobe
Sel  output  2  writeback mux select (0=MEM, 1=ALU, 2=IMM)
RegWrEn  output  1  RegFile write enable, sampled at rising Clk
RegWrAddr  output  REG_AW  RegFile write address
ErrIllegal  output  1  sticky flag: reserved source accepted

Behaviour:
- Clocking and reset: one clock domain (Clk). Reset is asynchronous and active-high.
- While Reset=1:
  - state=IDLE, counter=0, latched dst=0, ErrIllegal=0.
  - Combinational outputs resolve to: RegWrEn=0, MemRdEn=0, Sel=0, RegWrAddr=0, ReqReady=0, Stall=0.
- FSM states: IDLE, WAIT, WRITE. Counter is 4 bits.
- ReqReady: 1 only in IDLE and Reset=0. A handshake occurs when ReqValid & ReqReady.
- IDLE, handshake with ReqSrc=ALU or IMM:
  - Same cycle (combinational): Sel=ReqSrc, RegWrEn=1, RegWrAddr=ReqDst.
  - State stays IDLE, giving one request per cycle throughput.
- IDLE, handshake with ReqSrc=MEM:
  - Same cycle: MemRdEn=1, RegWrEn=0.
  - Latch ReqDst.
  - If MEM_LAT=1, next state is WRITE. Otherwise next state is WAIT with counter=MEM_LAT-1.
- IDLE, handshake with ReqSrc=3: no write and no read; ErrIllegal<=1 (held until Reset); state stays IDLE.
- IDLE, no handshake: RegWrEn=0, MemRdEn=0, Sel=0, RegWrAddr=0.
- WAIT:
  - Outputs: ReqReady=0, RegWrEn=0, MemRdEn=0, Sel=0, RegWrAddr=latched dst.
  - Each cycle the counter decrements; when counter==1, next state is WRITE.
- WRITE (exactly one cycle):
  - Outputs: Sel=0, RegWrEn=1, RegWrAddr=latched dst, ReqReady=0.
  - Next state is IDLE.
- Load timing: a load accepted in cycle N writes the RegFile at the end of cycle N+MEM_LAT. ReqReady=1 again in cycle N+MEM_LAT+1. The load occupies MEM_LAT+1 cycles total.
- Stall: held high for every cycle a request is presented while not in IDLE. ReqSrc/ReqDst presented while stalled are ignored and must be held by the source.
- Reset mid-load: the pending write is discarded. RegWrEn and MemRdEn drop immediately (asynchronous), with no late write after reset deasserts.
- RegWrEn and MemRdEn are never asserted in the same cycle.

Test Plan:
- Reset then IDLE, ReqValid=1, ReqSrc=1, ReqDst=5 -> same cycle Sel=1, RegWrEn=1, RegWrAddr=5, ReqReady=1, Stall=0.
- Back-to-back IMM (dst 2) then ALU (dst 3) on consecutive cycles -> two consecutive RegWrEn pulses, Sel=2 then 1, addresses 2 then 3.
- MEM_LAT=2, MEM load dst=6 accepted at cycle 10:
  - Cycle 10: MemRdEn=1.
  - Cycles 11–12: ReqReady=0.
  - Cycle 12: RegWrEn=1, Sel=0, RegWrAddr=6.
  - Cycle 13: ReqReady=1.
  - An ALU request held from cycle 11 has Stall=1 in cycles 11–12 and is accepted at cycle 13.
- MEM_LAT=1 build, load dst=4 at cycle N -> RegWrEn at N+1, ReqReady at N+2; no WAIT state visited.
- Reset asserted asynchronously mid-WAIT -> RegWrEn, MemRdEn and ReqReady are 0 immediately. After release, no write to the latched dst ever occurs, and the first request is accepted normally.
- ReqSrc=3 with ReqValid=1 -> no RegWrEn, no MemRdEn, ErrIllegal=1 from next cycle and stays 1 across later valid requests until Reset.
